rr_mux_2powern: RTL and testbench
=================================

Name: rr_mux_2powerN

Overview:
- Collecting counterpart of the 2^N-way bus demultiplexer in the MDR system.
- 2**MUX_SEL source ports each present a request and a DDW-bit data bus.
- The block arbitrates round-robin among the requesting sources, registers the winning bus, and presents it on a single output with a valid/ready handshake.
- Main use: returning results from parallel MDR units (multiplier/divider/root) to one shared consumer.

Parameters:
- MUX_SEL, 2, selector width; number of sources NS = 2**MUX_SEL.
- DDW, 16, data width of every bus.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- i_req  input  NS  per-source request, bit j belongs to source j.
- i_buses  input  NS x DDW  packed array; i_buses[j] is the data of source j.
- i_ready  input  1  downstream accepts o_bus this cycle.
- o_bus  output  DDW  registered winning data.
- o_valid  output  1  o_bus holds an unaccepted word.
- o_sltr  output  MUX_SEL  index of the source whose data is in o_bus.
- o_gnt  output  NS  one-hot grant pulse to the captured source.

Behaviour:
- Reset, while rst=0 and asynchronously:
  - o_bus=0, o_valid=0, o_sltr=0, o_gnt=0.
  - Priority pointer ptr=0, state=IDLE.
- Load condition: load = (!o_valid || i_ready) && (|i_req).
- Arbitration, evaluated only on load:
  - Winner w = first j with i_req[j]=1, searching ptr, ptr+1, …, NS-1, 0, …, ptr-1 (mod NS).
  - Search is combinational and completes in one cycle.
- On a load edge:
  - o_bus <= i_buses[w], o_sltr <= w, o_valid <= 1.
  - o_gnt <= one-hot(w).
  - ptr <= (w+1) mod NS; wraps NS-1 -> 0 with natural MUX_SEL-bit overflow.
- o_gnt is high for exactly one cycle, the first cycle o_valid shows the new word. It is 0 in every other cycle.
- Hold: while o_valid=1 and i_ready=0, o_bus, o_sltr and o_valid stay stable. New requests wait, no matter how their buses change.
- Accept: o_valid=1 and i_ready=1 consumes the word.
  - Same edge with a pending request: load the next winner (back-to-back, no bubble).
  - Same edge with no request: o_valid <= 0. o_bus and o_sltr keep their last values.
- State machine, state held as o_valid:
  - IDLE (o_valid=0): load -> HOLD; otherwise stay.
  - HOLD (o_valid=1): i_ready=0 -> HOLD; i_ready=1 with |i_req -> HOLD with new word; i_ready=1 with no request -> IDLE.
- Latency: a request seen at edge k gives o_valid and o_gnt after edge k, provided the output is free and the source wins.
- Source contract:
  - Hold i_req[j] and i_buses[j] stable until o_gnt[j] is seen.
  - Drop i_req[j] in the o_gnt cycle unless sending another word.
  - A request still high during o_gnt, with i_ready=1, counts as a new request.
  - It is served again only if no other source with higher priority after ptr is requesting.
- Fairness: with all NS sources requesting continuously and i_ready=1, grants cycle 0,1,…,NS-1,0. No source waits more than NS-1 accepted words.
- i_ready with o_valid=0 has no effect.
- Reset mid-transfer drops the held word. ptr returns to 0.
- No X propagation: i_buses of non-winning sources never reach o_bus.

Test Plan:
- Reset with i_req=4'b1111 held, then release rst -> all outputs 0 during reset. After the first edge: o_bus=i_buses[0], o_sltr=0, o_gnt=4'b0001, o_valid=1.
- Single source: i_req=4'b0100, i_buses[2]=16'hBEEF, i_ready=1 -> next cycle o_bus=16'hBEEF, o_sltr=2, o_gnt=4'b0100 for one cycle. When i_req drops, o_valid falls one cycle later.
- Fairness: i_req=4'b1111 constant, i_ready=1, 8 cycles -> o_sltr sequence 0,1,2,3,0,1,2,3 with o_valid continuously 1.
- Backpressure: capture source 1 (16'h1234), i_ready=0 for 5 cycles while i_buses[1] changes and i_req=4'b1000 -> o_bus stays 16'h1234 and o_sltr=1. On i_ready=1, the next cycle shows o_sltr=3, o_gnt=4'b1000.
- Wrap and skip: ptr=3 after a grant to source 2; i_req=4'b0011 -> winner 0, then 1. With i_req=4'b0001 only, consecutive grants stay on source 0.
- Async reset asserted mid-HOLD, between clock edges -> o_valid, o_bus and o_gnt drop to 0 immediately. After release, arbitration starts from ptr=0.

Source files
------------

// File: rtl/rr_mux_2powern.sv
// Round-robin collector: 2**MUX_SEL request/data sources merged onto one registered valid/ready output.
// Latency: one cycle from a winning request to o_valid/o_gnt; back-to-back words with no bubble.
// Backpressure: while o_valid=1 and i_ready=0 the output word is frozen and all requests wait.
module rr_mux_2powern #(
  parameter int MUX_SEL = 2,
  parameter int DDW     = 16,
  localparam int NS     = 2**MUX_SEL
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NS-1:0]                i_req,
  input  logic [NS-1:0][DDW-1:0]       i_buses,
  input  logic                         i_ready,
  output logic [DDW-1:0]               o_bus,
  output logic                         o_valid,
  output logic [MUX_SEL-1:0]           o_sltr,
  output logic [NS-1:0]                o_gnt
);

  // The output register occupancy is the whole state: IDLE = empty, HOLD = word pending.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state;
  logic [MUX_SEL-1:0] ptr;
  logic [MUX_SEL-1:0] win;
  logic [MUX_SEL-1:0] idx;
  logic               found;
  logic               load;
  logic [NS-1:0]      win_onehot;

  assign o_valid = (state == HOLD);

  // A new word may enter when the output is empty or being consumed this cycle.
  assign load = ((state == IDLE) || i_ready) && (|i_req);

  // Rotating priority search starting at ptr; index arithmetic wraps naturally at MUX_SEL bits.
  always_comb begin
    win   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NS; k++) begin
      idx = ptr + MUX_SEL'(k);
      if (!found && i_req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign win_onehot = {{(NS-1){1'b0}}, 1'b1} << win;

  // Output register, grant pulse and priority pointer update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      o_bus  <= '0;
      o_sltr <= '0;
      o_gnt  <= '0;
    end else begin
      o_gnt <= '0;
      case (state)
        IDLE: begin
          if (load) begin
            state  <= HOLD;
            o_bus  <= i_buses[win];
            o_sltr <= win;
            o_gnt  <= win_onehot;
            ptr    <= win + 1'b1;
          end
        end
        HOLD: begin
          if (load) begin
            o_bus  <= i_buses[win];
            o_sltr <= win;
            o_gnt  <= win_onehot;
            ptr    <= win + 1'b1;
          end else if (i_ready) begin
            // Word consumed with nobody waiting: keep last bus/index, just go empty.
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_2powern.sv
module tb_rr_mux_2powern;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0][15:0] buses;
  logic             ready;
  logic [15:0]      o_bus;
  logic             o_valid;
  logic [1:0]       o_sltr;
  logic [3:0]       o_gnt;

  int checks;
  int failures;

  typedef struct packed {
    logic        valid;
    logic [15:0] bus;
    logic [1:0]  sltr;
    logic [3:0]  gnt;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic        m_valid;
  logic [15:0] m_bus;
  logic [1:0]  m_sltr;
  logic [3:0]  m_gnt;
  int          m_ptr;

  rr_mux_2powern #(.MUX_SEL(2), .DDW(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req),
    .i_buses (buses),
    .i_ready (ready),
    .o_bus   (o_bus),
    .o_valid (o_valid),
    .o_sltr  (o_sltr),
    .o_gnt   (o_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_bus   = '0;
    m_sltr  = '0;
    m_gnt   = '0;
    m_ptr   = 0;
  endtask

  // Behavioural next-state of the collector for the inputs present at the coming edge.
  task automatic model_edge();
    logic ld;
    int   w;
    ld    = (!m_valid || ready) && (req != 4'b0000);
    m_gnt = 4'b0000;
    if (ld) begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (w < 0 && req[j]) w = j;
      end
      m_valid = 1'b1;
      m_bus   = buses[w];
      m_sltr  = 2'(w);
      m_gnt   = 4'(1 << w);
      m_ptr   = (w + 1) % 4;
    end else if (m_valid && ready) begin
      m_valid = 1'b0;
    end
  endtask

  // Push the expectation for the next edge, clock once, pop and compare.
  task automatic step(input string tag);
    exp_t e;
    model_edge();
    e.valid = m_valid;
    e.bus   = m_bus;
    e.sltr  = m_sltr;
    e.gnt   = m_gnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".valid"}, 32'(o_valid), 32'(e.valid));
    chk({tag, ".bus"},   32'(o_bus),   32'(e.bus));
    chk({tag, ".sltr"},  32'(o_sltr),  32'(e.sltr));
    chk({tag, ".gnt"},   32'(o_gnt),   32'(e.gnt));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();

    // Reset with all sources requesting
    rst      = 1'b0;
    req      = 4'b1111;
    ready    = 1'b1;
    buses[0] = 16'hA000;
    buses[1] = 16'hA111;
    buses[2] = 16'hA222;
    buses[3] = 16'hA333;
    #12;
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.bus",   32'(o_bus),   32'd0);
    chk("rst.sltr",  32'(o_sltr),  32'd0);
    chk("rst.gnt",   32'(o_gnt),   32'd0);
    rst = 1'b1;

    // First edge after reset grants source 0, then fairness rotation
    step("first");
    chk("first.gnt_onehot", 32'(o_gnt), 32'h1);
    for (int i = 1; i < 8; i++) begin
      step("fair");
      chk("fair.seq", 32'(o_sltr), 32'(i % 4));
    end

    // Single source
    req      = 4'b0100;
    buses[2] = 16'hBEEF;
    step("single");
    chk("single.beef", 32'(o_bus), 32'hBEEF);
    req = 4'b0000;
    step("single.drop");
    chk("single.fall", 32'(o_valid), 32'd0);
    step("idle");

    // Backpressure: capture source 1 then hold while its bus changes
    req      = 4'b0010;
    buses[1] = 16'h1234;
    step("bp.cap");
    req   = 4'b1000;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      buses[1] = 16'($urandom);
      step("bp.hold");
      chk("bp.bus_stable", 32'(o_bus), 32'h1234);
    end
    ready = 1'b1;
    step("bp.rel");
    chk("bp.next_sltr", 32'(o_sltr), 32'd3);

    // Wrap and skip: grant 2 leaves ptr at 3
    req = 4'b0100;
    step("wrap.g2");
    req = 4'b0011;
    step("wrap.w0");
    chk("wrap.w0_sltr", 32'(o_sltr), 32'd0);
    req = 4'b0010;
    step("wrap.w1");
    chk("wrap.w1_sltr", 32'(o_sltr), 32'd1);
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step("repeat0");
      chk("repeat0.gnt", 32'(o_gnt), 32'h1);
    end

    // Random request/ready/data traffic
    for (int i = 0; i < 40; i++) begin
      req   = 4'($urandom_range(0, 15));
      ready = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++) buses[j] = 16'($urandom);
      step("rnd");
    end

    // Async reset in the middle of a held word
    req   = 4'b0100;
    ready = 1'b0;
    step("ar.hold");
    chk("ar.pre_valid", 32'(o_valid), 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("ar.valid", 32'(o_valid), 32'd0);
    chk("ar.bus",   32'(o_bus),   32'd0);
    chk("ar.gnt",   32'(o_gnt),   32'd0);
    model_reset();
    #3;
    rst   = 1'b1;
    req   = 4'b1111;
    ready = 1'b1;
    step("ar.restart");
    chk("ar.ptr0", 32'(o_sltr), 32'd0);
    step("ar.next");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
